// File: rtl/psr.sv
// CR16 processor status register: masked flag latch, one-deep interrupt shadow,
// and registered condition-code evaluation with same-cycle write bypass.
module psr #(
  parameter logic [4:0] P_RESET_VALUE = 5'b00000
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic [4:0] I_STATUS,
  input  logic [4:0] I_WRITE_MASK,
  input  logic       I_SAVE,
  input  logic       I_RESTORE,
  input  logic [3:0] I_COND,
  input  logic       I_COND_VALID,
  output logic [4:0] O_PSR,
  output logic [4:0] O_SHADOW,
  output logic       O_COND_MET,
  output logic       O_COND_VALID
);

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_HI = 4'h4, CC_LS = 4'h5, CC_GT = 4'h6, CC_LE = 4'h7,
    CC_FS = 4'h8, CC_FC = 4'h9, CC_LO = 4'hA, CC_HS = 4'hB,
    CC_LT = 4'hC, CC_GE = 4'hD, CC_UC = 4'hE, CC_NV = 4'hF
  } cond_e;

  // Flag bit positions within the status vector.
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_L = 1;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 4;

  logic [4:0] psr_q, psr_d;
  logic [4:0] shadow_q, shadow_d;
  logic       cond_met_q, cond_met_d;
  logic       cond_valid_q, cond_valid_d;
  logic       cond_true;

  // Restore takes priority and drops any concurrent mask write; with I_SAVE the
  // shadow captures the pre-update PSR, so save+restore swaps the two.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    psr_d    = (psr_q & ~I_WRITE_MASK) | (I_STATUS & I_WRITE_MASK);
    shadow_d = shadow_q;
    if (I_RESTORE) psr_d = shadow_q;
    if (I_SAVE)    shadow_d = psr_q;
  end

  // Evaluate against psr_d so a flag write in this cycle is seen by a branch
  // resolving in the same cycle.
  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(I_COND))
      CC_EQ:   cond_true =  psr_d[FLAG_Z];
      CC_NE:   cond_true = ~psr_d[FLAG_Z];
      CC_CS:   cond_true =  psr_d[FLAG_C];
      CC_CC:   cond_true = ~psr_d[FLAG_C];
      CC_HI:   cond_true =  psr_d[FLAG_L];
      CC_LS:   cond_true = ~psr_d[FLAG_L];
      CC_GT:   cond_true =  psr_d[FLAG_N];
      CC_LE:   cond_true = ~psr_d[FLAG_N];
      CC_FS:   cond_true =  psr_d[FLAG_F];
      CC_FC:   cond_true = ~psr_d[FLAG_F];
      CC_LO:   cond_true = ~psr_d[FLAG_L] & ~psr_d[FLAG_Z];
      CC_HS:   cond_true =  psr_d[FLAG_L] |  psr_d[FLAG_Z];
      CC_LT:   cond_true = ~psr_d[FLAG_N] & ~psr_d[FLAG_Z];
      CC_GE:   cond_true =  psr_d[FLAG_N] |  psr_d[FLAG_Z];
      CC_UC:   cond_true = 1'b1;
      CC_NV:   cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  assign cond_met_d   = I_COND_VALID & cond_true;
  assign cond_valid_d = I_COND_VALID;

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (I_RESET) begin
      psr_q        <= P_RESET_VALUE;
      shadow_q     <= P_RESET_VALUE;
      cond_met_q   <= 1'b0;
      cond_valid_q <= 1'b0;
    end else begin
      psr_q        <= psr_d;
      shadow_q     <= shadow_d;
      cond_met_q   <= cond_met_d;
      cond_valid_q <= cond_valid_d;
    end
  end

  assign O_PSR        = psr_q;
  assign O_SHADOW     = shadow_q;
  assign O_COND_MET   = cond_met_q;
  assign O_COND_VALID = cond_valid_q;

endmodule

// File: tb/tb_psr.sv
// Self-checking bench for psr: expectations from an independent flag model are
// queued at drive time and compared against the DUT one edge later.
module tb_psr;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] status, mask;
  logic       save, restore;
  logic [3:0] cond;
  logic       cond_valid;
  logic [4:0] psr_o, shadow_o;
  logic       met_o, valid_o;

  psr #(.P_RESET_VALUE(5'b00000)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_STATUS(status), .I_WRITE_MASK(mask),
    .I_SAVE(save), .I_RESTORE(restore), .I_COND(cond), .I_COND_VALID(cond_valid),
    .O_PSR(psr_o), .O_SHADOW(shadow_o), .O_COND_MET(met_o), .O_COND_VALID(valid_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] psr;
    logic [4:0] shadow;
    logic       met;
    logic       vld;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] m_psr, m_shadow;
  int         n_total = 0;
  int         n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // Condition table written directly from named flags.
  function automatic logic model_cond(input logic [3:0] code, input logic [4:0] p);
    logic c, l, f, z, n;
    {n, z, f, l, c} = p;
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return l;
      4'd5:  return !l;
      4'd6:  return n;
      4'd7:  return !n;
      4'd8:  return f;
      4'd9:  return !f;
      4'd10: return !l && !z;
      4'd11: return l || z;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [4:0] st, input logic [4:0] mk, input logic sv,
                       input logic rs, input logic [3:0] cc, input logic cv,
                       input string tag);
    exp_t e;
    logic [4:0] nxt;
    status = st; mask = mk; save = sv; restore = rs; cond = cc; cond_valid = cv;
    nxt = m_psr;
    for (int k = 0; k < 5; k++) if (mk[k]) nxt[k] = st[k];
    if (rs) nxt = m_shadow;
    e.shadow = sv ? m_psr : m_shadow;
    e.psr    = nxt;
    e.met    = cv && model_cond(cc, nxt);
    e.vld    = cv;
    sb.push_back(e);
    m_psr    = e.psr;
    m_shadow = e.shadow;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_psr"},    {27'd0, psr_o},    {27'd0, e.psr});
      check({tag, "_shadow"}, {27'd0, shadow_o}, {27'd0, e.shadow});
      check({tag, "_met"},    {31'd0, met_o},    {31'd0, e.met});
      check({tag, "_valid"},  {31'd0, valid_o},  {31'd0, e.vld});
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_psr"},    {27'd0, psr_o},    32'd0);
    check({tag, "_shadow"}, {27'd0, shadow_o}, 32'd0);
    check({tag, "_met"},    {31'd0, met_o},    32'd0);
    check({tag, "_valid"},  {31'd0, valid_o},  32'd0);
  endtask

  initial begin
    logic [4:0] sweep_vals [6];
    sweep_vals = '{5'b00000, 5'b01000, 5'b00010, 5'b10000, 5'b00100, 5'b00001};
    rst = 1'b1; status = '0; mask = '0; save = 0; restore = 0; cond = '0; cond_valid = 0;
    m_psr = '0; m_shadow = '0;
    #2;
    check_reset_state("por");
    #6 rst = 1'b0;   // released between edges

    // Masked write touches only Z.
    drive(5'b11111, 5'b11111, 0, 0, 4'd0, 0, "set_all");
    drive(5'b00000, 5'b01000, 0, 0, 4'd0, 0, "mask_z");
    check("mask_z_literal", {27'd0, psr_o}, 32'b10111);
    drive(5'b00000, 5'b00000, 0, 0, 4'd14, 1, "mul_nomask");

    // Bypass: write Z and evaluate EQ in the same cycle.
    drive(5'b00000, 5'b11111, 0, 0, 4'd0, 0, "clr");
    drive(5'b01000, 5'b11111, 0, 0, 4'd0, 1, "bypass");
    check("bypass_met_literal", {31'd0, met_o}, 32'd1);

    // Code sweep: bypassed write, then the same code against the held PSR.
    foreach (sweep_vals[i]) begin
      for (int c = 0; c < 16; c++) begin
        drive(sweep_vals[i], 5'b11111, 0, 0, 4'(c), 1, $sformatf("sw%0d_c%0d", i, c));
        drive(5'b11111, 5'b00000, 0, 0, 4'(c), 1, $sformatf("hold%0d_c%0d", i, c));
      end
    end
    drive(5'b00000, 5'b11111, 0, 0, 4'd10, 1, "lo_zero");
    check("lo_zero_literal", {31'd0, met_o}, 32'd1);
    drive(5'b00000, 5'b00000, 0, 0, 4'd15, 1, "never");
    check("never_literal", {31'd0, met_o}, 32'd0);
    drive(5'b00000, 5'b00000, 0, 0, 4'd14, 0, "invalid_clears");

    // Save / write / restore-with-mask.
    drive(5'b10101, 5'b11111, 0, 0, 4'd0, 0, "pre_save");
    drive(5'b00000, 5'b00000, 1, 0, 4'd0, 0, "save");
    drive(5'b01010, 5'b11111, 0, 0, 4'd0, 0, "write_after_save");
    drive(5'b01010, 5'b11111, 0, 1, 4'd0, 1, "restore");
    check("restore_psr_literal",    {27'd0, psr_o},    32'b10101);
    check("restore_shadow_literal", {27'd0, shadow_o}, 32'b10101);

    // Swap.
    drive(5'b11000, 5'b11111, 0, 0, 4'd0, 0, "swap_a");
    drive(5'b00011, 5'b11111, 1, 0, 4'd0, 0, "swap_b");
    drive(5'b00000, 5'b00000, 1, 1, 4'd0, 0, "swap");
    check("swap_psr_literal",    {27'd0, psr_o},    32'b11000);
    check("swap_shadow_literal", {27'd0, shadow_o}, 32'b00011);
    drive(5'b10101, 5'b11111, 1, 0, 4'd2, 1, "save_write");

    // Random traffic.
    for (int t = 0; t < 300; t++)
      drive(5'($urandom), 5'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) == 0), 4'($urandom), 1'($urandom),
            $sformatf("rnd%0d", t));

    // Reset asserted mid-cycle with a pending write: immediate clear.
    drive(5'b11111, 5'b11111, 1, 0, 4'd14, 1, "pre_rst");
    #3 rst = 1'b1;
    #1 check_reset_state("async_rst");
    status = 5'b11111; mask = 5'b11111; save = 1; cond = 4'd14; cond_valid = 1;
    @(posedge clk); #1;
    check_reset_state("rst_held");
    #3 rst = 1'b0;
    m_psr = '0; m_shadow = '0; sb.delete();
    drive(5'b00110, 5'b00110, 0, 0, 4'd4, 1, "post_rst");
    check("post_rst_literal", {27'd0, psr_o}, 32'b00110);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
